// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ADDR_STEP    = 32'd4;
    localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0;

    // One FIFO entry: the fetched instruction and the byte address it came from.
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [WORD_W-1:0] addr;
    } fetch_entry_t;

    // One slot of the RAM return pipe; epoch marks which fetch stream issued it.
    typedef struct packed {
        logic              valid;
        logic              epoch;
        logic [WORD_W-1:0] addr;
    } ret_slot_t;

    // Force an address onto a word boundary.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
        return a & ~(WORD_W'(3));
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// The producer guarantees it never pushes into a full FIFO.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    // Next-state: flush wins over push/pop; pop on an empty FIFO is ignored.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop_ok);
        end
    end

    // State registers; storage is cleared on reset so the head reads as zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch queue: issues sequential RAM reads ahead of the core,
// tracks them through a fixed-latency return pipe and buffers the words.
// A redirect flushes the FIFO and flips the epoch so in-flight returns drop.
//
// Handshake: readReq is a one-cycle pulse whose ramAddress is valid in the
// same cycle; ramIn is taken exactly RAM_LATENCY cycles later. On the core
// side the head is consumed at the edge where popReq=1 and instValid=1.
//
// readReq/ramAddress are registered, so the issue decision for the next
// cycle is made from next-cycle occupancy and credit. inflight counts the
// read currently on readReq plus every read still in the return pipe.
module instruction_prefetch
    import fetch_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int RAM_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_W-1:0]      ramIn,
    output logic [WORD_W-1:0]      ramAddress,
    output logic                   readReq,
    output logic                   instValid,
    output logic [WORD_W-1:0]      instWord,
    output logic [WORD_W-1:0]      instAddr,
    input  logic                   popReq,
    input  logic                   redirect,
    input  logic [WORD_W-1:0]      redirectAddr,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    ret_slot_t         pipe_q [RAM_LATENCY];
    ret_slot_t         pipe_d [RAM_LATENCY];
    logic [WORD_W-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [WORD_W-1:0] ram_address_q, ram_address_d;
    logic              read_req_q, read_req_d;
    logic              epoch_q, epoch_d;
    logic [CW-1:0]     inflight_q, inflight_d;

    fetch_entry_t      fifo_head;
    fetch_entry_t      fifo_in;
    logic [CW-1:0]     fifo_count;
    logic              fifo_push;
    logic              fifo_pop;
    logic              ret_valid;
    logic [CW-1:0]     occ_next;
    logic [CW-1:0]     inflight_left;
    logic [CW:0]       credit_sum;
    logic              issue_next;
    logic [WORD_W-1:0] next_ptr;

    // Return, pop, credit and issue decisions for the coming edge.
    always_comb begin
        ret_valid     = pipe_q[RAM_LATENCY-1].valid;
        fifo_push     = ret_valid && (pipe_q[RAM_LATENCY-1].epoch == epoch_q) && !redirect;
        fifo_pop      = popReq && (fifo_count != '0) && !redirect;
        fifo_in       = '{word: ramIn, addr: pipe_q[RAM_LATENCY-1].addr};

        occ_next      = redirect ? '0 : (fifo_count + CW'(fifo_push) - CW'(fifo_pop));
        inflight_left = inflight_q - CW'(ret_valid);
        credit_sum    = {1'b0, occ_next} + {1'b0, inflight_left};
        issue_next    = credit_sum < DEPTH_C;

        next_ptr      = redirect ? align_word(redirectAddr) : fetch_ptr_q;
        read_req_d    = issue_next;
        ram_address_d = issue_next ? next_ptr : ram_address_q;
        fetch_ptr_d   = issue_next ? (next_ptr + ADDR_STEP) : next_ptr;
        inflight_d    = inflight_left + CW'(issue_next);
        epoch_d       = redirect ? ~epoch_q : epoch_q;

        // The read on the bus this cycle enters the pipe tagged with the
        // epoch it was issued under, so a redirect now marks it stale.
        pipe_d[0] = '{valid: read_req_q, epoch: epoch_q, addr: ram_address_q};
        for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // State registers; reset discards every outstanding read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_ptr_q   <= RESET_VECTOR;
            ram_address_q <= '0;
            read_req_q    <= 1'b0;
            epoch_q       <= 1'b0;
            inflight_q    <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            fetch_ptr_q   <= fetch_ptr_d;
            ram_address_q <= ram_address_d;
            read_req_q    <= read_req_d;
            epoch_q       <= epoch_d;
            inflight_q    <= inflight_d;
            pipe_q        <= pipe_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign readReq    = read_req_q;
    assign ramAddress = ram_address_q;
    assign instValid  = (fifo_count != '0);
    assign instWord   = fifo_head.word;
    assign instAddr   = fifo_head.addr;
    assign occupancy  = fifo_count;

endmodule
